// File: rtl/dir_requester_if.sv
// dir_requester_if: home-agent op, directory lookup/update and response signals of dir_requester
// master: the requester (drives op_ready, lookup_*/update_* requests, resp_*)
// slave: home agent plus directory (drives op_*, lookup results, update_done, resp_ready)
`ifndef WADDR
`define WADDR 16
`endif
`ifndef NUM_L1_CACHES
`define NUM_L1_CACHES 4
`endif
interface dir_requester_if #(
  parameter int SRC_W = 2
);
  logic                      op_valid;
  logic                      op_ready;
  logic [1:0]                op_type;
  logic [`WADDR-1:0]         op_addr;
  logic [SRC_W-1:0]          op_src;
  logic                      lookup_req;
  logic [`WADDR-1:0]         lookup_addr;
  logic                      lookup_valid;
  logic [2:0]                lookup_state;
  logic [`NUM_L1_CACHES-1:0] lookup_presence;
  logic [`NUM_L1_CACHES-1:0] lookup_tip_state;
  logic                      update_req;
  logic [`WADDR-1:0]         update_addr;
  logic [2:0]                update_state;
  logic [`NUM_L1_CACHES-1:0] update_presence;
  logic [`NUM_L1_CACHES-1:0] update_tip_state;
  logic                      update_done;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [`NUM_L1_CACHES-1:0] resp_probe_mask;
  logic [2:0]                resp_prev_state;
  logic [2:0]                resp_new_state;
  logic                      resp_error;
  modport master (
    input  op_valid, op_type, op_addr, op_src, lookup_valid, lookup_state, lookup_presence,
           lookup_tip_state, update_done, resp_ready,
    output op_ready, lookup_req, lookup_addr, update_req, update_addr, update_state,
           update_presence, update_tip_state, resp_valid, resp_probe_mask, resp_prev_state,
           resp_new_state, resp_error
  );
  modport slave (
    output op_valid, op_type, op_addr, op_src, lookup_valid, lookup_state, lookup_presence,
           lookup_tip_state, update_done, resp_ready,
    input  op_ready, lookup_req, lookup_addr, update_req, update_addr, update_state,
           update_presence, update_tip_state, resp_valid, resp_probe_mask, resp_prev_state,
           resp_new_state, resp_error
  );
endinterface

// File: rtl/dir_requester.sv
// dir_requester: one-op-at-a-time directory lookup/calc/update initiator for the home agent
// clk, rst_n: clock and asynchronous active-low reset
// dir (dir_requester_if.master): op in, lookup/update handshake to the directory, response out
`ifndef WADDR
`define WADDR 16
`endif
`ifndef NUM_L1_CACHES
`define NUM_L1_CACHES 4
`endif
`ifndef DIR_STATE_INVALID
`define DIR_STATE_INVALID 3'd0
`endif
`ifndef DIR_STATE_SHARED
`define DIR_STATE_SHARED 3'd1
`endif
`ifndef DIR_STATE_EXCLUSIVE
`define DIR_STATE_EXCLUSIVE 3'd2
`endif
module dir_requester #(
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  dir_requester_if.master dir
);
  localparam int N  = `NUM_L1_CACHES;
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, LREQ, LWAIT, CALC, UREQ, UWAIT, RESP} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_type;
  logic [SRC_W-1:0]  r_src;
  logic [`WADDR-1:0] r_addr;
  logic [N-1:0]      r_p, r_t, r_probe, r_up, r_ut;
  logic [2:0]        r_prev, r_us;
  logic              r_op_ready, r_lreq, r_ureq, r_rv, r_err;
  logic              w_accept, w_illegal, w_to;
  logic [N-1:0]      w_s, w_rel_p, w_rel_t, w_probe, w_np, w_nt;
  logic [2:0]        w_ns;
  assign w_accept  = r_op_ready && dir.op_valid;
  assign w_illegal = dir.op_type == 2'd3 || 32'(dir.op_src) >= N;
  assign w_to      = r_cnt == CW'(TIMEOUT - 1);
  assign w_s       = N'(1) << r_src;
  assign w_rel_p   = r_p & ~w_s;
  assign w_rel_t   = r_t & ~w_s;
  assign w_probe   = r_type == 2'd0 ? r_t & ~w_s : r_type == 2'd1 ? r_p & ~w_s : '0;
  assign w_np      = r_type == 2'd0 ? r_p | w_s : r_type == 2'd1 ? w_s : w_rel_p;
  assign w_nt      = r_type == 2'd0 ? '0 : r_type == 2'd1 ? w_s : w_rel_t;
  assign w_ns      = r_type == 2'd0 ? `DIR_STATE_SHARED :
                     r_type == 2'd1 ? `DIR_STATE_EXCLUSIVE :
                     ~|w_rel_p ? `DIR_STATE_INVALID :
                     |w_rel_t ? `DIR_STATE_EXCLUSIVE : `DIR_STATE_SHARED;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_illegal ? RESP : LREQ;
      LREQ:    w_next = LWAIT;
      LWAIT:   w_next = dir.lookup_valid ? CALC : w_to ? RESP : LWAIT;
      CALC:    w_next = UREQ;
      UREQ:    w_next = UWAIT;
      UWAIT:   if (dir.update_done || w_to) w_next = RESP;
      RESP:    if (dir.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_type     <= '0;
      r_src      <= '0;
      r_addr     <= '0;
      r_p        <= '0;
      r_t        <= '0;
      r_probe    <= '0;
      r_up       <= '0;
      r_ut       <= '0;
      r_prev     <= '0;
      r_us       <= '0;
      r_op_ready <= 1'b1;
      r_lreq     <= 1'b0;
      r_ureq     <= 1'b0;
      r_rv       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_op_ready <= w_next == IDLE;
      r_lreq     <= w_next == LREQ;
      r_ureq     <= w_next == UREQ;
      r_rv       <= w_next == RESP;
      r_cnt      <= (r_state == LWAIT || r_state == UWAIT) ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_type  <= dir.op_type;
        r_src   <= dir.op_src;
        r_addr  <= dir.op_addr;
        r_err   <= w_illegal;
        r_probe <= '0;
        r_prev  <= '0;
        r_us    <= '0;
      end
      if (r_state == LWAIT && dir.lookup_valid) begin
        r_prev <= dir.lookup_state;
        r_p    <= dir.lookup_presence;
        r_t    <= dir.lookup_tip_state;
      end
      if (r_state == CALC) begin
        r_probe <= w_probe;
        r_up    <= w_np;
        r_ut    <= w_nt;
        r_us    <= w_ns;
      end
      // update_done wins over a timeout landing in the same cycle
      if ((r_state == LWAIT && w_next == RESP) || (r_state == UWAIT && w_to && !dir.update_done))
        r_err <= 1'b1;
    end
  end
  assign dir.op_ready         = r_op_ready;
  assign dir.lookup_req       = r_lreq;
  assign dir.lookup_addr      = r_addr;
  assign dir.update_req       = r_ureq;
  assign dir.update_addr      = r_addr;
  assign dir.update_state     = r_us;
  assign dir.update_presence  = r_up;
  assign dir.update_tip_state = r_ut;
  assign dir.resp_valid       = r_rv;
  assign dir.resp_probe_mask  = r_probe;
  assign dir.resp_prev_state  = r_prev;
  assign dir.resp_new_state   = r_us;
  assign dir.resp_error       = r_err;
endmodule

// File: tb/tb_dir_requester.sv
// tb_dir_requester: randomized self-checking bench for dir_requester against a directory model
`ifndef WADDR
`define WADDR 16
`endif
`ifndef NUM_L1_CACHES
`define NUM_L1_CACHES 4
`endif
`ifndef DIR_STATE_INVALID
`define DIR_STATE_INVALID 3'd0
`endif
`ifndef DIR_STATE_SHARED
`define DIR_STATE_SHARED 3'd1
`endif
`ifndef DIR_STATE_EXCLUSIVE
`define DIR_STATE_EXCLUSIVE 3'd2
`endif
module tb_dir_requester;
  localparam int N  = `NUM_L1_CACHES;
  localparam int AW = `WADDR;
  localparam int SW = 3;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vec = 0;
  int bad = 0;
  logic [2:0]   mem_s [int];
  logic [N-1:0] mem_p [int];
  logic [N-1:0] mem_t [int];
  dir_requester_if #(.SRC_W(SW)) bus ();
  dir_requester #(.SRC_W(SW), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .dir(bus));
  always #5 clk = ~clk;
  function automatic void ref_calc(input int op, input int src, input logic [N-1:0] p,
                                   input logic [N-1:0] t, output logic [N-1:0] probe,
                                   output logic [N-1:0] np, output logic [N-1:0] nt,
                                   output logic [2:0] ns);
    logic [N-1:0] s;
    s = '0;
    s[src] = 1'b1;
    if (op == 0) begin
      probe = t & ~s; np = p | s; nt = '0; ns = `DIR_STATE_SHARED;
    end else if (op == 1) begin
      probe = p & ~s; np = s; nt = s; ns = `DIR_STATE_EXCLUSIVE;
    end else begin
      probe = '0; np = p & ~s; nt = t & ~s;
      ns = (np == '0) ? `DIR_STATE_INVALID : (nt != '0) ? `DIR_STATE_EXCLUSIVE : `DIR_STATE_SHARED;
    end
  endfunction
  task automatic idle_inputs();
    bus.op_valid = 1'b0;
    bus.op_type = '0;
    bus.op_addr = '0;
    bus.op_src = '0;
    bus.lookup_valid = 1'b0;
    bus.lookup_state = '0;
    bus.lookup_presence = '0;
    bus.lookup_tip_state = '0;
    bus.update_done = 1'b0;
    bus.resp_ready = 1'b0;
  endtask
  // One full op with the bench acting as home agent and directory; call and return at a negedge.
  task automatic do_op(input int op, input int addr, input int src, input int lat_l, input int lat_u,
                       input int hold, input bit drop_l, input bit drop_u, input string tag);
    bit legal, prev_req, hs, fin, lv_done, x_err;
    int k, nl, nu, lcyc, ucyc, rcyc, both, consec, exp_ucyc, exp_rcyc;
    logic [N-1:0] p, t, e_probe, e_np, e_nt, x_probe;
    logic [2:0] s, e_ns, x_prev, x_new;
    legal = op != 3 && src < N;
    s = mem_s.exists(addr) ? mem_s[addr] : `DIR_STATE_INVALID;
    p = mem_p.exists(addr) ? mem_p[addr] : '0;
    t = mem_t.exists(addr) ? mem_t[addr] : '0;
    e_probe = '0; e_np = '0; e_nt = '0; e_ns = `DIR_STATE_INVALID;
    if (legal) ref_calc(op, src, p, t, e_probe, e_np, e_nt, e_ns);
    exp_ucyc = 3 + lat_l;
    exp_rcyc = !legal ? 1 : drop_l ? 2 + TO : drop_u ? exp_ucyc + 1 + TO : exp_ucyc + lat_u + 1;
    x_err   = !legal || drop_l || drop_u;
    x_probe = (legal && !drop_l) ? e_probe : '0;
    x_prev  = (legal && !drop_l) ? s : 3'd0;
    x_new   = (legal && !drop_l) ? e_ns : 3'd0;
    k = 0; nl = 0; nu = 0; lcyc = 0; ucyc = 0; rcyc = 0; both = 0; consec = 0;
    prev_req = 0; hs = 0; fin = 0; lv_done = 0;
    if (bus.op_ready !== 1'b1) begin
      bad++; $display("FAIL %s op_ready_at_issue got %b want 1", tag, bus.op_ready);
    end
    vec++;
    bus.op_valid = 1'b1;
    bus.op_type = op[1:0];
    bus.op_addr = AW'(addr);
    bus.op_src = SW'(src);
    @(posedge clk);
    while (!fin && k < 80) begin
      @(negedge clk);
      k++;
      bus.op_valid = 1'b0;
      bus.op_type = 2'($urandom);
      bus.op_addr = AW'($urandom);
      bus.op_src = SW'($urandom);
      if (bus.lookup_req) begin
        nl++;
        if (nl == 1) lcyc = k;
        if (bus.lookup_addr !== AW'(addr)) begin
          bad++; $display("FAIL %s lookup_addr got %h want %h", tag, bus.lookup_addr, AW'(addr));
        end
        vec++;
      end
      if (bus.update_req) begin
        nu++;
        if (nu == 1) ucyc = k;
      end
      if (ucyc != 0 && (k == ucyc || k == ucyc + 1)) begin
        if ({bus.update_addr, bus.update_state, bus.update_presence, bus.update_tip_state} !==
            {AW'(addr), e_ns, e_np, e_nt}) begin
          bad++;
          $display("FAIL %s update_fields cyc%0d got a=%h s=%0d p=%b t=%b want a=%h s=%0d p=%b t=%b",
                   tag, k, bus.update_addr, bus.update_state, bus.update_presence,
                   bus.update_tip_state, AW'(addr), e_ns, e_np, e_nt);
        end
        vec++;
      end
      if (bus.lookup_req && bus.update_req) both++;
      if ((bus.lookup_req || bus.update_req) && prev_req) consec++;
      prev_req = bus.lookup_req || bus.update_req;
      if (hs) begin
        if ({bus.resp_valid, bus.op_ready} !== 2'b01) begin
          bad++; $display("FAIL %s after_accept valid/ready got %b%b want 01", tag, bus.resp_valid, bus.op_ready);
        end
        vec++;
        fin = 1;
      end else if (bus.resp_valid) begin
        if (rcyc == 0) rcyc = k;
        if ({bus.resp_probe_mask, bus.resp_prev_state, bus.resp_new_state, bus.resp_error} !==
            {x_probe, x_prev, x_new, x_err}) begin
          bad++;
          $display("FAIL %s resp_fields cyc%0d got probe=%b prev=%0d new=%0d err=%b want probe=%b prev=%0d new=%0d err=%b",
                   tag, k, bus.resp_probe_mask, bus.resp_prev_state, bus.resp_new_state,
                   bus.resp_error, x_probe, x_prev, x_new, x_err);
        end
        if (bus.op_ready !== 1'b0) begin
          bad++; $display("FAIL %s op_ready_in_resp got %b want 0", tag, bus.op_ready);
        end
        vec += 2;
      end else begin
        if (bus.op_ready !== 1'b0) begin
          bad++; $display("FAIL %s op_ready_busy cyc%0d got %b want 0", tag, k, bus.op_ready);
        end
        vec++;
      end
      if (fin) idle_inputs();
      else begin
        if (lcyc != 0 && !drop_l && k == lcyc + lat_l) begin
          bus.lookup_valid = 1'b1;
          bus.lookup_state = s;
          bus.lookup_presence = p;
          bus.lookup_tip_state = t;
          lv_done = 1;
        end else begin
          bus.lookup_valid = (lv_done || !legal) && $urandom_range(0, 2) == 0;
          bus.lookup_state = 3'($urandom);
          bus.lookup_presence = N'($urandom);
          bus.lookup_tip_state = N'($urandom);
        end
        if (ucyc != 0 && !drop_u && k == ucyc + lat_u) begin
          bus.update_done = 1'b1;
          mem_s[addr] = e_ns;
          mem_p[addr] = e_np;
          mem_t[addr] = e_nt;
        end else bus.update_done = ucyc == 0 && $urandom_range(0, 2) == 0;
        if (bus.resp_valid) begin
          bus.resp_ready = (k - rcyc) >= hold;
          hs = bus.resp_ready;
        end else bus.resp_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!fin) begin
      bad++; $display("FAIL %s no_completion within %0d cycles", tag, k);
      idle_inputs();
    end
    if (nl !== int'(legal)) begin
      bad++; $display("FAIL %s lookup_req_count got %0d want %0d", tag, nl, int'(legal));
    end
    if (legal && lcyc != 1) begin
      bad++; $display("FAIL %s lookup_req_cycle got %0d want 1", tag, lcyc);
    end
    if (nu !== int'(legal && !drop_l)) begin
      bad++; $display("FAIL %s update_req_count got %0d want %0d", tag, nu, int'(legal && !drop_l));
    end
    if (legal && !drop_l && ucyc != exp_ucyc) begin
      bad++; $display("FAIL %s update_req_cycle got %0d want %0d", tag, ucyc, exp_ucyc);
    end
    if (rcyc != exp_rcyc) begin
      bad++; $display("FAIL %s resp_cycle got %0d want %0d", tag, rcyc, exp_rcyc);
    end
    if (both != 0 || consec != 0) begin
      bad++; $display("FAIL %s req_spacing got both=%0d consec=%0d want 0 0", tag, both, consec);
    end
    vec += 6;
  endtask
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    if ({bus.lookup_req, bus.lookup_addr, bus.update_req, bus.update_addr, bus.update_state,
         bus.update_presence, bus.update_tip_state, bus.resp_valid, bus.resp_probe_mask,
         bus.resp_prev_state, bus.resp_new_state, bus.resp_error} !== '0 || bus.op_ready !== 1'b1) begin
      bad++; $display("FAIL reset_values got ready=%b lreq=%b ureq=%b rv=%b err=%b want ready=1 others 0",
                      bus.op_ready, bus.lookup_req, bus.update_req, bus.resp_valid, bus.resp_error);
    end
    vec++;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.lookup_valid = 1'($urandom_range(0, 1));
      bus.update_done = 1'($urandom_range(0, 1));
      bus.resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if ({bus.op_ready, bus.lookup_req, bus.update_req, bus.resp_valid} !== 4'b1000) begin
        bad++; $display("FAIL idle_cycle%0d got ready/lreq/ureq/rv=%b want 1000", i,
                        {bus.op_ready, bus.lookup_req, bus.update_req, bus.resp_valid});
      end
      vec++;
    end
    idle_inputs();
  endtask
  task automatic test_acq_shared_empty();
    do_op(0, 'h45, 1, 2, 2, 0, 0, 0, "shared_empty");
  endtask
  task automatic test_acq_excl();
    mem_s['h80] = `DIR_STATE_SHARED; mem_p['h80] = 4'b0110; mem_t['h80] = 4'b0000;
    do_op(1, 'h80, 2, 2, 2, 0, 0, 0, "excl");
  endtask
  task automatic test_release_then_shared();
    do_op(2, 'h80, 2, 2, 2, 0, 0, 0, "release");
    mem_s['h90] = `DIR_STATE_EXCLUSIVE; mem_p['h90] = 4'b1000; mem_t['h90] = 4'b1000;
    do_op(0, 'h90, 0, 2, 2, 0, 0, 0, "shared_after_excl");
  endtask
  task automatic test_timeout();
    do_op(0, 'h20, 1, 2, 2, 0, 1, 0, "lookup_timeout");
    do_op(1, 'h21, 3, 2, 2, 0, 0, 1, "update_timeout");
  endtask
  task automatic test_illegal();
    do_op(3, 'h22, 1, 2, 2, 0, 0, 0, "reserved_op");
    do_op(0, 'h23, 4, 2, 2, 1, 0, 0, "src_4");
    do_op(1, 'h24, 7, 2, 2, 0, 0, 0, "src_7");
  endtask
  task automatic test_hold();
    mem_s['h50] = `DIR_STATE_SHARED; mem_p['h50] = 4'b1011; mem_t['h50] = 4'b0000;
    do_op(1, 'h50, 0, 2, 2, 5, 0, 0, "resp_hold");
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) do_op($urandom_range(0, 2), 'h30 + i % 2, i % 4, 1, 1, 0, 0, 0, "b2b");
  endtask
  task automatic test_reset_mid();
    bus.op_valid = 1'b1; bus.op_type = 2'd0; bus.op_addr = AW'('hA0); bus.op_src = SW'(3);
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    if (bus.lookup_req !== 1'b1) begin
      bad++; $display("FAIL rstmid lookup_req got %b want 1", bus.lookup_req);
    end
    vec++;
    @(negedge clk);
    @(negedge clk);
    bus.lookup_valid = 1'b1; bus.lookup_state = `DIR_STATE_INVALID;
    bus.lookup_presence = '0; bus.lookup_tip_state = '0;
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    @(negedge clk);
    if (bus.update_req !== 1'b1) begin
      bad++; $display("FAIL rstmid update_req got %b want 1", bus.update_req);
    end
    vec++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if ({bus.lookup_req, bus.lookup_addr, bus.update_req, bus.update_addr, bus.update_state,
         bus.update_presence, bus.update_tip_state, bus.resp_valid, bus.resp_probe_mask,
         bus.resp_prev_state, bus.resp_new_state, bus.resp_error} !== '0 || bus.op_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_outputs got ready=%b ua=%h us=%0d up=%b rv=%b want ready=1 others 0",
                      bus.op_ready, bus.update_addr, bus.update_state, bus.update_presence, bus.resp_valid);
    end
    vec++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.update_done = 1'b1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.update_done = 1'b0;
      if ({bus.op_ready, bus.lookup_req, bus.update_req, bus.resp_valid} !== 4'b1000) begin
        bad++; $display("FAIL rstmid_after%0d got ready/lreq/ureq/rv=%b want 1000", i,
                        {bus.op_ready, bus.lookup_req, bus.update_req, bus.resp_valid});
      end
      vec++;
    end
    idle_inputs();
  endtask
  task automatic test_random();
    int op, src;
    for (int i = 0; i < 8; i++) begin
      mem_s['h10 + i] = 3'($urandom_range(0, 2));
      mem_p['h10 + i] = N'($urandom);
      mem_t['h10 + i] = N'($urandom);
    end
    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(0, 5) == 0 ? 3 : $urandom_range(0, 2);
      src = $urandom_range(0, 9) == 0 ? $urandom_range(4, 7) : $urandom_range(0, 3);
      do_op(op, 'h10 + $urandom_range(0, 7), src, $urandom_range(1, 4), $urandom_range(1, 4),
            $urandom_range(0, 3), $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, "random");
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_acq_shared_empty();
    test_acq_excl();
    test_release_then_shared();
    test_timeout();
    test_illegal();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
